// File: rtl/lte_ul_tdl_test_gen.sv
// Uplink TDL test-data generator: replaces antenna-TDM IQ with gated test patterns.
// Define UL_TDL_PRBS_EN to enable the PRBS15 source on src 3 (otherwise src 3 passes i_data).
module lte_ul_tdl_test_gen #(
  parameter int ANT_NUM = 8,
  parameter int IQ_W    = 16,
  parameter int CYC_NUM = 192,
  parameter int SGN_NUM = 200,
  localparam int AW = (ANT_NUM > 1) ? $clog2(ANT_NUM) : 1,
  localparam int CW = $clog2(CYC_NUM),
  localparam int DW = 2 * IQ_W
) (
  input  logic               clk_245,
  input  logic               asy_rst_n,
  input  logic               i_fram_hd,
  input  logic               i_ant_sel,
  input  logic [DW-1:0]      i_data,
  input  logic               i_ac_flag,
  input  logic [2:0]         i_src_sel,
  input  logic [IQ_W-1:0]    i_const_i,
  input  logic [IQ_W-1:0]    i_const_q,
  input  logic [15:0]        i_win_start,
  input  logic [15:0]        i_win_end,
  input  logic               i_ac_gate_en,
  input  logic [ANT_NUM-1:0] i_ant_mask,
  input  logic [1:0]         i_bw_sel,
  output logic               o_fram_hd,
  output logic               o_ant_sel,
  output logic [AW-1:0]      o_ant_idx,
  output logic [DW-1:0]      o_data,
  output logic               o_data_valid,
  output logic               o_frm_err
);

  function automatic logic [IQ_W-1:0] fit_iq(input logic [31:0] v);
    return IQ_W'(v);
  endfunction

`ifdef UL_TDL_PRBS_EN
  function automatic logic [14:0] prbs_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction
`endif

  logic               hd_p0_q, hd_p0_d, ant_sel_p0_q, ant_sel_p0_d, ac_p0_q, ac_p0_d, vld_p0_q, vld_p0_d;
  logic [DW-1:0]      data_p0_q, data_p0_d;
  logic [2:0]         src_p0_q, src_p0_d;
  logic [IQ_W-1:0]    const_i_p0_q, const_i_p0_d, const_q_p0_q, const_q_p0_d;
  logic [15:0]        win_start_p0_q, win_start_p0_d, win_end_p0_q, win_end_p0_d;
  logic               ac_gate_p0_q, ac_gate_p0_d;
  logic [ANT_NUM-1:0] mask_p0_q, mask_p0_d;
  logic [1:0]         bw_p0_q, bw_p0_d;

  logic [2:0]         src_q, src_d;
  logic [IQ_W-1:0]    const_i_q, const_i_d, const_q_q, const_q_d;
  logic [15:0]        win_start_q, win_start_d, win_end_q, win_end_d;
  logic               ac_gate_q, ac_gate_d;
  logic [ANT_NUM-1:0] mask_q, mask_d;
  logic [1:0]         bw_q, bw_d;

  logic [CW-1:0]      cycle_q, cycle_d;
  logic [4:0]         chip_q, chip_d;
  logic [7:0]         sgn_q, sgn_d;
  logic [AW-1:0]      slot_q, slot_d;
  logic               first_q, first_d;
  logic               cyc_wrap, chip_wrap, frm_end;

  logic               hd_p1_q, hd_p1_d, ant_sel_p1_q, ant_sel_p1_d, ac_p1_q, ac_p1_d;
  logic               vld_p1_q, vld_p1_d, err_p1_q, err_p1_d;
  logic [DW-1:0]      data_p1_q, data_p1_d;

  logic               fram_hd_q, fram_hd_d, ant_sel_q, ant_sel_d, vld_q, vld_d, frm_err_q, frm_err_d;
  logic [AW-1:0]      ant_idx_q, ant_idx_d;
  logic [DW-1:0]      data_q, data_d;

  logic [12:0]        chip_num;
  logic               in_win, gate, bw_vld;
  logic [IQ_W-1:0]    pat_i, pat_q;

`ifdef UL_TDL_PRBS_EN
  logic [14:0]        lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = hd_p0_q ? 15'h7FFF : prbs_step(lfsr_q);
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) lfsr_q <= 15'h7FFF;
    else            lfsr_q <= lfsr_d;
  end
`endif

  // Stage p0: capture input sample and the configuration presented alongside it
  always_comb begin
    hd_p0_d        = i_fram_hd & i_ant_sel;
    ant_sel_p0_d   = i_ant_sel;
    ac_p0_d        = i_ac_flag;
    vld_p0_d       = 1'b1;
    data_p0_d      = i_data;
    src_p0_d       = i_src_sel;
    const_i_p0_d   = i_const_i;
    const_q_p0_d   = i_const_q;
    win_start_p0_d = i_win_start;
    win_end_p0_d   = i_win_end;
    ac_gate_p0_d   = i_ac_gate_en;
    mask_p0_d      = i_ant_mask;
    bw_p0_d        = i_bw_sel;
  end

  // Stage p1: shadow load, counters and frame cadence check
  always_comb begin
    src_d       = src_q;
    const_i_d   = const_i_q;
    const_q_d   = const_q_q;
    win_start_d = win_start_q;
    win_end_d   = win_end_q;
    ac_gate_d   = ac_gate_q;
    mask_d      = mask_q;
    bw_d        = bw_q;
    if (hd_p0_q) begin
      src_d       = src_p0_q;
      const_i_d   = const_i_p0_q;
      const_q_d   = const_q_p0_q;
      win_start_d = win_start_p0_q;
      win_end_d   = win_end_p0_q;
      ac_gate_d   = ac_gate_p0_q;
      mask_d      = mask_p0_q;
      bw_d        = bw_p0_q;
    end
  end

  always_comb begin
    cyc_wrap  = (cycle_q == CW'(CYC_NUM - 1));
    chip_wrap = cyc_wrap && (chip_q == 5'd31);
    frm_end   = chip_wrap && (sgn_q == 8'(SGN_NUM - 1));
    cycle_d   = cyc_wrap ? '0 : cycle_q + 1'b1;
    chip_d    = cyc_wrap ? chip_q + 1'b1 : chip_q;
    sgn_d     = sgn_q;
    if (chip_wrap) sgn_d = (sgn_q == 8'(SGN_NUM - 1)) ? '0 : sgn_q + 1'b1;
    slot_d    = (ant_sel_p0_q || (slot_q == AW'(ANT_NUM - 1))) ? '0 : slot_q + 1'b1;
    first_d   = first_q;
    err_p1_d  = 1'b0;
    // A header exactly on the natural frame wrap is in cadence
    if (hd_p0_q) begin
      cycle_d  = '0;
      chip_d   = '0;
      sgn_d    = '0;
      slot_d   = '0;
      first_d  = 1'b0;
      err_p1_d = ~first_q & ~frm_end;
    end
    hd_p1_d      = hd_p0_q;
    ant_sel_p1_d = ant_sel_p0_q;
    ac_p1_d      = ac_p0_q;
    vld_p1_d     = vld_p0_q;
    data_p1_d    = data_p0_q;
  end

  // Output stage: pattern selection, gating and bandwidth valid
  always_comb begin
    chip_num = {sgn_q, chip_q};
    in_win   = ({3'b000, chip_num} >= win_start_q) && ({3'b000, chip_num} <= win_end_q);
    gate     = vld_p1_q && in_win && mask_q[slot_q] && (ac_p1_q || !ac_gate_q);
    pat_i    = data_p1_q[DW-1:IQ_W];
    pat_q    = data_p1_q[IQ_W-1:0];
    case (src_q)
      3'd1: begin
        pat_i = const_i_q;
        pat_q = const_q_q;
      end
      3'd2: begin
        pat_i = fit_iq(32'(chip_num));
        pat_q = fit_iq(32'({slot_q, cycle_q}));
      end
`ifdef UL_TDL_PRBS_EN
      3'd3: begin
        pat_i = fit_iq(32'(lfsr_q));
        pat_q = ~fit_iq(32'(lfsr_q));
      end
`endif
      3'd4: begin
        pat_i = fit_iq(32'(slot_q));
        pat_q = ~fit_iq(32'(slot_q));
      end
      default: ;
    endcase
    case (bw_q)
      2'd3:    bw_vld = 1'b1;
      2'd0:    bw_vld = (cycle_q[4:3] == 2'b00);
      default: bw_vld = ~cycle_q[3];
    endcase
    data_d    = gate ? {pat_i, pat_q} : '0;
    vld_d     = vld_p1_q & bw_vld;
    fram_hd_d = hd_p1_q;
    ant_sel_d = ant_sel_p1_q;
    ant_idx_d = vld_p1_q ? slot_q : '0;
    frm_err_d = err_p1_q;
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      hd_p0_q        <= 1'b0;
      ant_sel_p0_q   <= 1'b0;
      ac_p0_q        <= 1'b0;
      vld_p0_q       <= 1'b0;
      data_p0_q      <= '0;
      src_p0_q       <= '0;
      const_i_p0_q   <= '0;
      const_q_p0_q   <= '0;
      win_start_p0_q <= '0;
      win_end_p0_q   <= '0;
      ac_gate_p0_q   <= 1'b0;
      mask_p0_q      <= '0;
      bw_p0_q        <= '0;
      src_q          <= '0;
      const_i_q      <= '0;
      const_q_q      <= '0;
      win_start_q    <= '0;
      win_end_q      <= 16'hFFFF;
      ac_gate_q      <= 1'b0;
      mask_q         <= '1;
      bw_q           <= 2'd3;
      cycle_q        <= '0;
      chip_q         <= '0;
      sgn_q          <= '0;
      slot_q         <= '0;
      first_q        <= 1'b1;
      hd_p1_q        <= 1'b0;
      ant_sel_p1_q   <= 1'b0;
      ac_p1_q        <= 1'b0;
      vld_p1_q       <= 1'b0;
      err_p1_q       <= 1'b0;
      data_p1_q      <= '0;
      fram_hd_q      <= 1'b0;
      ant_sel_q      <= 1'b0;
      vld_q          <= 1'b0;
      frm_err_q      <= 1'b0;
      ant_idx_q      <= '0;
      data_q         <= '0;
    end else begin
      hd_p0_q        <= hd_p0_d;
      ant_sel_p0_q   <= ant_sel_p0_d;
      ac_p0_q        <= ac_p0_d;
      vld_p0_q       <= vld_p0_d;
      data_p0_q      <= data_p0_d;
      src_p0_q       <= src_p0_d;
      const_i_p0_q   <= const_i_p0_d;
      const_q_p0_q   <= const_q_p0_d;
      win_start_p0_q <= win_start_p0_d;
      win_end_p0_q   <= win_end_p0_d;
      ac_gate_p0_q   <= ac_gate_p0_d;
      mask_p0_q      <= mask_p0_d;
      bw_p0_q        <= bw_p0_d;
      src_q          <= src_d;
      const_i_q      <= const_i_d;
      const_q_q      <= const_q_d;
      win_start_q    <= win_start_d;
      win_end_q      <= win_end_d;
      ac_gate_q      <= ac_gate_d;
      mask_q         <= mask_d;
      bw_q           <= bw_d;
      cycle_q        <= cycle_d;
      chip_q         <= chip_d;
      sgn_q          <= sgn_d;
      slot_q         <= slot_d;
      first_q        <= first_d;
      hd_p1_q        <= hd_p1_d;
      ant_sel_p1_q   <= ant_sel_p1_d;
      ac_p1_q        <= ac_p1_d;
      vld_p1_q       <= vld_p1_d;
      err_p1_q       <= err_p1_d;
      data_p1_q      <= data_p1_d;
      fram_hd_q      <= fram_hd_d;
      ant_sel_q      <= ant_sel_d;
      vld_q          <= vld_d;
      frm_err_q      <= frm_err_d;
      ant_idx_q      <= ant_idx_d;
      data_q         <= data_d;
    end
  end

  assign o_fram_hd    = fram_hd_q;
  assign o_ant_sel    = ant_sel_q;
  assign o_ant_idx    = ant_idx_q;
  assign o_data       = data_q;
  assign o_data_valid = vld_q;
  assign o_frm_err    = frm_err_q;

endmodule
